// File: rtl/mmio_csr_bank.sv
// CCI-P MMIO CSR bank: AFU feature header, host control registers, datapath status registers.
// Optional free-running cycle counter at 0x000A is enabled by defining MMIO_CSR_CYCLE_COUNTER_EN.

package ccip_if_pkg;
  typedef logic [15:0]  t_ccip_mmioAddr;
  typedef logic [8:0]   t_ccip_tid;
  typedef logic [63:0]  t_ccip_mmioData;
  typedef logic [511:0] t_ccip_clData;

  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef logic [$bits(t_ccip_c0_ReqMmioHdr)-1:0] t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;
endpackage

module mmio_csr_bank
  import ccip_if_pkg::*;
#(
  parameter logic [127:0] AFU_ID      = '0,
  parameter int           NUM_RW_REGS = 8,
  parameter int           NUM_RO_REGS = 4,
  parameter logic [63:0]  RW_RESET    = '0,
  localparam int          RO_W        = (NUM_RO_REGS > 0) ? 64 * NUM_RO_REGS : 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  t_if_ccip_c0_Rx             rx,
  input  logic [RO_W-1:0]            ro_regs,
  output t_if_ccip_c2_Tx             tx,
  output logic [64*NUM_RW_REGS-1:0]  rw_regs,
  output logic [NUM_RW_REGS-1:0]     wr_strobe
);

  localparam int          RO_N      = (NUM_RO_REGS > 0) ? NUM_RO_REGS : 1;
  localparam int          RW_IW     = (NUM_RW_REGS > 1) ? $clog2(NUM_RW_REGS) : 1;
  localparam int          RO_IW     = (RO_N > 1) ? $clog2(RO_N) : 1;
  localparam logic [14:0] RW_BASE_W = 15'd8;
  localparam logic [14:0] RO_BASE_W = 15'(8 + NUM_RW_REGS);
  localparam logic [14:0] RO_END_W  = 15'(8 + NUM_RW_REGS + NUM_RO_REGS);
  localparam logic [63:0] DFH       = 64'h1000_0100_0000_0000;

  t_ccip_c0_ReqMmioHdr req;
  logic [14:0]         word;
  logic                half, is_8b, misaligned;
  logic                in_rw, in_ro, wr_ok, wr_rw, err_clr, rd_mis, wr_mis;
  logic [RW_IW-1:0]    rw_idx;
  logic [RO_IW-1:0]    ro_idx;
  logic [63:0]         rw_q [NUM_RW_REGS];
  logic [63:0]         ro_w [RO_N];
  logic [31:0]         err_q;
  logic [32:0]         err_sum;
  logic [63:0]         cyc_val, rd_word, rd_data;
  logic                rd_v1;
  t_ccip_tid           rd_tid1;
  logic [63:0]         rd_data1;

  // Address is in 4-byte units; bit 0 selects the 32-bit half of a 64-bit word.
  assign req        = t_ccip_c0_ReqMmioHdr'(rx.hdr);
  assign word       = req.address[15:1];
  assign half       = req.address[0];
  assign is_8b      = (req.length == 2'b01);
  assign misaligned = is_8b & half;

  assign in_rw   = (word >= RW_BASE_W) && (word < RO_BASE_W);
  assign in_ro   = (word >= RO_BASE_W) && (word < RO_END_W);
  assign rw_idx  = RW_IW'(word - RW_BASE_W);
  assign ro_idx  = RO_IW'(word - RO_BASE_W);
  assign wr_ok   = rx.mmioWrValid & ~misaligned;
  assign wr_rw   = wr_ok & in_rw;
  assign err_clr = wr_ok & (word == 15'd6);
  assign rd_mis  = rx.mmioRdValid & misaligned;
  assign wr_mis  = rx.mmioWrValid & misaligned;
  assign err_sum = {1'b0, err_q} + 33'(rd_mis) + 33'(wr_mis);

  for (genvar i = 0; i < NUM_RW_REGS; i++) begin : g_rw_out
    assign rw_regs[64*i +: 64] = rw_q[i];
  end
  for (genvar j = 0; j < RO_N; j++) begin : g_ro_in
    assign ro_w[j] = ro_regs[64*j +: 64];
  end

`ifdef MMIO_CSR_CYCLE_COUNTER_EN
  logic [63:0] cyc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_q + 64'd1;
  end
  assign cyc_val = cyc_q;
`else
  assign cyc_val = '0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_word = '0;
    if (word == 15'd0)      rd_word = DFH;
    else if (word == 15'd1) rd_word = AFU_ID[63:0];
    else if (word == 15'd2) rd_word = AFU_ID[127:64];
    else if (word == 15'd5) rd_word = cyc_val;
    else if (word == 15'd6) rd_word = {32'h0, err_q};
    else if (in_rw)         rd_word = rw_q[rw_idx];
    else if (in_ro)         rd_word = ro_w[ro_idx];
  end

  always_comb begin
    rd_data = '0;
    if (!misaligned) rd_data = is_8b ? rd_word : {32'h0, half ? rd_word[63:32] : rd_word[31:0]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the control array is reset in full because software relies on RW_RESET after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RW_REGS; i++) rw_q[i] <= RW_RESET;
      wr_strobe <= '0;
    end else begin
      wr_strobe <= '0;
      if (wr_rw) begin
        wr_strobe[rw_idx] <= 1'b1;
        if (is_8b)     rw_q[rw_idx]        <= rx.data[63:0];
        else if (half) rw_q[rw_idx][63:32] <= rx.data[31:0];
        else           rw_q[rw_idx][31:0]  <= rx.data[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= '0;
    else if (err_clr) err_q <= '0;
    else              err_q <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
  end

  // Stage 1 captures pre-write contents, so a same-cycle write is not visible to the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1    <= 1'b0;
      rd_tid1  <= '0;
      rd_data1 <= '0;
      tx       <= '0;
    end else begin
      rd_v1          <= rx.mmioRdValid;
      rd_tid1        <= req.tid;
      rd_data1       <= rd_data;
      tx.mmioRdValid <= rd_v1;
      tx.hdr.tid     <= rd_tid1;
      tx.data        <= rd_data1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{rx.data[511:64], rx.rspValid, req.rsvd};

endmodule

// File: tb/tb_mmio_csr_bank.sv
// Self-checking bench for mmio_csr_bank: vector table plus hand sequences, read responses
// matched against an in-order scoreboard; honours MMIO_CSR_CYCLE_COUNTER_EN if defined.
module tb_mmio_csr_bank;
  import ccip_if_pkg::*;

  localparam logic [127:0] AFU_ID   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [63:0]  RW_RESET = 64'hCAFE_F00D_0000_0001;
  localparam logic [63:0]  DFH      = 64'h1000_0100_0000_0000;
  localparam logic [1:0]   LEN4     = 2'b00;
  localparam logic [1:0]   LEN8     = 2'b01;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  t_if_ccip_c0_Rx    rx;
  logic [255:0]      ro_regs;
  t_if_ccip_c2_Tx    tx;
  logic [511:0]      rw_regs;
  logic [7:0]        wr_strobe;

  mmio_csr_bank #(
    .AFU_ID(AFU_ID), .NUM_RW_REGS(8), .NUM_RO_REGS(4), .RW_RESET(RW_RESET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .ro_regs(ro_regs),
    .tx(tx), .rw_regs(rw_regs), .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  len;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
    bit          cmp;
    string       name;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  logic [63:0] cap_q[$];
  sb_t         mon_e;
  int          cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Drive one cycle of request; reads optionally push their expected response.
  task automatic drive(input logic rd, input logic wr, input logic [1:0] len, input logic [15:0] addr,
                       input logic [63:0] wdata, input logic [8:0] tid, input logic [63:0] exp,
                       input bit cmp, input bit push, input string name);
    t_ccip_c0_ReqMmioHdr h;
    sb_t e;
    @(posedge clk); #1;
    h = '0;
    h.address = addr;
    h.length  = len;
    h.tid     = tid;
    rx = '0;
    rx.hdr = t_ccip_c0_RspMemHdr'(h);
    rx.data = {448'h0, wdata};
    rx.mmioRdValid = rd;
    rx.mmioWrValid = wr;
    if (rd && push) begin
      e.tid = tid; e.data = exp; e.due = cyc + 2; e.cmp = cmp; e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, LEN8, 16'h0, 64'h0, 9'h0, 64'h0, 1'b0, 1'b0, "idle");
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      idle(1);
      k++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && tx.mmioRdValid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_tid"}, 64'(tx.hdr.tid), 64'(mon_e.tid));
        check({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.due));
        if (mon_e.cmp) check({mon_e.name, "_data"}, tx.data, mon_e.data);
        else cap_q.push_back(tx.data);
      end
    end
  end

  initial begin
    logic [63:0] c0, c1;
    rx = '0;
    ro_regs = {64'h3333_0000_0000_3333, 64'h2222_BBBB_0000_2222, 64'h1111, 64'hA5A5};

    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h0000, 64'h0, DFH});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h0002, 64'h0, 64'hFEDC_BA98_7654_3210});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h0004, 64'h0, 64'h0123_4567_89AB_CDEF});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h0006, 64'h0, 64'h0});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h0008, 64'h0, 64'h0});
    vecs.push_back('{1'b1, 1'b0, LEN4, 16'h0003, 64'h0, 64'hFEDC_BA98});
    vecs.push_back('{1'b1, 1'b0, LEN4, 16'h0010, 64'h0, 64'h3333_4444});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h0010, 64'h0, 64'hDEAD_BEEF_3333_4444});
    vecs.push_back('{1'b0, 1'b1, LEN4, 16'h0012, 64'h9999_9999_5555_6666, 64'h0});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h0012, 64'h0, {RW_RESET[63:32], 32'h5555_6666}});
    vecs.push_back('{1'b0, 1'b1, LEN8, 16'h0000, 64'hFFFF, 64'h0});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h0000, 64'h0, DFH});
    vecs.push_back('{1'b0, 1'b1, LEN8, 16'h0100, 64'h1234, 64'h0});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h0100, 64'h0, 64'h0});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h001E, 64'h0, RW_RESET});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h0020, 64'h0, 64'hA5A5});
    vecs.push_back('{1'b1, 1'b0, LEN4, 16'h0025, 64'h0, 64'h2222_BBBB});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h0026, 64'h0, 64'h3333_0000_0000_3333});
    vecs.push_back('{1'b0, 1'b1, LEN8, 16'h0020, 64'h1, 64'h0});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h0020, 64'h0, 64'hA5A5});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h0028, 64'h0, 64'h0});
    vecs.push_back('{1'b1, 1'b0, LEN8, 16'h000C, 64'h0, 64'h0});

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tx", 64'(tx), 64'h0);
    check("rst_strobe", 64'(wr_strobe), 64'h0);
    check("rst_rw", rw_regs[63:0] ^ rw_regs[511:448], 64'h0);
    check("rst_rw0", rw_regs[63:0], RW_RESET);
    check("rst_rw7", rw_regs[511:448], RW_RESET);
    @(posedge clk); #1 rst_n = 1'b1;

    // Partial write: 8B then 4B upper half, two strobe pulses
    drive(1'b0, 1'b1, LEN8, 16'h0010, 64'h1111_2222_3333_4444, 9'h0, 64'h0, 1'b0, 1'b0, "w8");
    drive(1'b0, 1'b1, LEN4, 16'h0011, 64'hDEAD_BEEF, 9'h0, 64'h0, 1'b0, 1'b0, "w4");
    @(negedge clk);
    check("pw_rw_8b", rw_regs[63:0], 64'h1111_2222_3333_4444);
    check("pw_strobe1", 64'(wr_strobe), 64'h01);
    idle(1);
    @(negedge clk);
    check("pw_rw_4b", rw_regs[63:0], 64'hDEAD_BEEF_3333_4444);
    check("pw_strobe2", 64'(wr_strobe), 64'h01);
    idle(1);
    @(negedge clk);
    check("pw_strobe_off", 64'(wr_strobe), 64'h00);

    // Table, issued back to back
    for (int i = 0; i < vecs.size(); i++)
      drive(vecs[i].rd, vecs[i].wr, vecs[i].len, vecs[i].addr, vecs[i].wdata,
            (i < 3) ? 9'd5 : 9'(i), vecs[i].exp, 1'b1, 1'b1, $sformatf("vec%0d", i));
    idle(1);
    drain();

    // Misaligned accesses and error register clear
    drive(1'b0, 1'b1, LEN8, 16'h0011, 64'hFFFF_FFFF_FFFF_FFFF, 9'h0, 64'h0, 1'b0, 1'b0, "mis_w");
    idle(1);
    @(negedge clk);
    check("mis_strobe", 64'(wr_strobe), 64'h0);
    check("mis_rw", rw_regs[63:0], 64'hDEAD_BEEF_3333_4444);
    drive(1'b1, 1'b0, LEN8, 16'h000C, 64'h0, 9'h10, 64'd1, 1'b1, 1'b1, "err1");
    drive(1'b1, 1'b0, LEN8, 16'h0013, 64'h0, 9'h11, 64'd0, 1'b1, 1'b1, "mis_rd");
    drive(1'b1, 1'b0, LEN8, 16'h000C, 64'h0, 9'h12, 64'd2, 1'b1, 1'b1, "err2");
    drive(1'b0, 1'b1, LEN4, 16'h000C, 64'h5A, 9'h0, 64'h0, 1'b0, 1'b0, "err_clr");
    drive(1'b1, 1'b0, LEN8, 16'h000C, 64'h0, 9'h13, 64'd0, 1'b1, 1'b1, "err0");
    idle(1);
    drain();

    // Pipelined reads with a colliding write in the middle cycle
    drive(1'b1, 1'b0, LEN8, 16'h0010, 64'h0, 9'h20, 64'hDEAD_BEEF_3333_4444, 1'b1, 1'b1, "col0");
    drive(1'b1, 1'b1, LEN8, 16'h0010, 64'h7, 9'h21, 64'hDEAD_BEEF_3333_4444, 1'b1, 1'b1, "col1");
    drive(1'b1, 1'b0, LEN8, 16'h0010, 64'h0, 9'h22, 64'h7, 1'b1, 1'b1, "col2");
    idle(1);
    drain();
    check("col_rw", rw_regs[63:0], 64'h7);

    // Cycle counter: two reads ten cycles apart
    drive(1'b1, 1'b0, LEN8, 16'h000A, 64'h0, 9'h30, 64'h0, 1'b0, 1'b1, "cnt0");
    idle(9);
    drive(1'b1, 1'b0, LEN8, 16'h000A, 64'h0, 9'h31, 64'h0, 1'b0, 1'b1, "cnt1");
    idle(1);
    drain();
    check("cnt_count", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() == 2) begin
      c0 = cap_q[0];
      c1 = cap_q[1];
`ifdef MMIO_CSR_CYCLE_COUNTER_EN
      check("cnt_delta", c1 - c0, 64'd10);
`else
      check("cnt_off0", c0, 64'd0);
      check("cnt_off1", c1, 64'd0);
`endif
    end

    // Reset mid-operation: the in-flight read must never respond
    drive(1'b0, 1'b1, LEN8, 16'h0009, 64'h0, 9'h0, 64'h0, 1'b0, 1'b0, "pre_mis");
    drive(1'b1, 1'b0, LEN8, 16'h0000, 64'h0, 9'h40, 64'h0, 1'b0, 1'b0, "lost");
    @(posedge clk); #1;
    rx = '0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_tx", 64'(tx), 64'h0);
    check("mrst_rw0", rw_regs[63:0], RW_RESET);
    check("mrst_strobe", 64'(wr_strobe), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(4);
    drive(1'b1, 1'b0, LEN8, 16'h0010, 64'h0, 9'h41, RW_RESET, 1'b1, 1'b1, "post_rw0");
    drive(1'b1, 1'b0, LEN8, 16'h000C, 64'h0, 9'h42, 64'h0, 1'b1, 1'b1, "post_err");
    idle(1);
    drain();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mmio_csr_bank.md
# mmio_csr_bank

Parametrised CCI-P MMIO register bank for the AFU. It decodes MMIO reads and writes from the c0 receive channel and answers reads on the c2 transmit channel. It hosts the mandatory AFU feature header (DFH, AFU ID, reserved words), a configurable number of host-writable control registers with per-register write strobes, and a configurable number of read-only status registers driven by the datapath. It supports both 4-byte and 8-byte accesses and uses a fixed-latency pipelined read path.

## Interface
- Parameters:
- AFU_ID, 128'h0, value returned at AFU_ID_L/AFU_ID_H.
- NUM_RW_REGS, 8, number of 64-bit control registers (1..64).
- NUM_RO_REGS, 4, number of 64-bit status registers (0..64).
- RW_RESET, 64'h0, reset value of every control register.
- Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx  in  t_if_ccip_c0_Rx  MMIO requests; header cast to t_ccip_c0_ReqMmioHdr (address in 4-byte units, length 2'b00=4B, 2'b01=8B, tid).
- ro_regs  in  64*NUM_RO_REGS  status values; register j is bits [64j+63:64j].
- tx  out  t_if_ccip_c2_Tx  MMIO read responses.
- rw_regs  out  64*NUM_RW_REGS  current control register contents.
- wr_strobe  out  NUM_RW_REGS  one-cycle pulse per control register written.

## Operation
- Address map (4-byte units, 8B words at even addresses):
- 0x0000 DFH: type=4'b0001, end-of-list=1, all other fields 0.
- 0x0002/0x0004: AFU_ID[63:0]/[127:64].
- 0x0006, 0x0008: reserved, read 0.
- 0x000A: cycle counter (see Configuration).
- 0x000C: error register, bits [31:0] hold the misaligned-access count, upper bits read 0.
- 0x0010+2i: control register i.
- 0x0010+2*NUM_RW_REGS+2j: status register j.
- Unmapped addresses read 0, and writes to them are ignored. Writes to the header, counter and status addresses are ignored. A write of any value to 0x000C clears the error count.
- 8B access: the address must be even. If it is odd, the access is misaligned: a write is dropped, a read returns 0, and in both cases the error count increments (saturating at 32'hFFFF_FFFF).
- 4B write: updates only the half selected by address[0] (0 = [31:0], 1 = [63:32]) using rx.data[31:0]. The other half is preserved.
- 4B read: the response carries the selected half in data[31:0], and data[63:32]=0.
- wr_strobe[i] pulses for any accepted write (4B or 8B) to control register i.
- If rx.mmioRdValid and rx.mmioWrValid are both asserted, both are serviced. The read returns the value from before the write.

## Timing
- Reset: rw_regs=RW_RESET in every register, wr_strobe=0, tx='0 (including mmioRdValid=0), error count=0, cycle counter=0, read pipeline cleared.
- Write: a request in cycle N updates rw_regs and pulses wr_strobe in cycle N+1, 1 cycle wide.
- Read: two-stage pipeline.
  - Stage 1: the request is sampled in cycle N, and the address decode, tid, length and register contents are captured at the end of N.
  - Stage 2: tx.mmioRdValid=1 in cycle N+2, with tx.hdr.tid equal to the request tid.
  - Latency is exactly 2 cycles.
  - Back-to-back reads every cycle are supported. Responses return in request order, one per cycle.
- A read in cycle N observes all writes from cycles before N, but not a write in cycle N.
- tx.mmioRdValid is a single-cycle pulse per read. tx.data is don't-care when valid=0.
- Reset asserted mid-operation: in-flight reads are discarded (no response), and all state returns to its reset values.
- Error counter and cycle counter are read through the same 2-cycle path. The sampled value is the one at the end of cycle N.

## Configuration
- MMIO_CSR_CYCLE_COUNTER_EN defined:
  - A 64-bit free-running counter increments every cycle after reset and wraps from 2^64-1 to 0.
  - It is readable at 0x000A (8B or 4B halves).
- Not defined: no counter is instantiated, and 0x000A reads 0.

## Test plan
- Header and ID: with AFU_ID=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 8B reads of 0x0000/0x0002/0x0004 with tid=5 → data 64'h1000_0100_0000_0000 / 64'hFEDC_BA98_7654_3210 / 64'h0123_4567_89AB_CDEF, valid exactly 2 cycles later, tid=5.
- Partial write: 8B write of 64'h1111_2222_3333_4444 to 0x0010, then a 4B write of 32'hDEAD_BEEF to 0x0011 → rw_regs[63:0]=64'hDEAD_BEEF_3333_4444, wr_strobe[0] pulses twice (1 cycle each), and a 4B read of 0x0010 returns 64'h0000_0000_3333_4444.
- Status and unmapped: ro_regs[63:0]=64'hA5A5 with NUM_RW_REGS=8 → a read of 0x0020 returns 64'hA5A5, and a read of 0x0100 returns 0.
- Misaligned: an 8B write to 0x0011 leaves rw_regs unchanged with no strobe, and a read of 0x000C returns 1. A write to 0x000C followed by a read returns 0.
- Pipeline and collision: reads of 0x0010 in cycles N, N+1, N+2 with a write of 64'h7 to 0x0010 in cycle N+1 → responses in N+2, N+3, N+4 with data old, old, 7.
- Counter (with MMIO_CSR_CYCLE_COUNTER_EN): two 8B reads of 0x000A issued 10 cycles apart → values differ by 10. Without the macro, both reads return 0.
